// File: rtl/fthread_pipe_link.sv
// Buffered, credit-controlled link between two adjacent fthreads.
// Requests (consumer -> producer) pass through a 2-entry skid buffer,
// responses (producer -> consumer) through a DEPTH-entry FIFO whose head
// is held in an output register. A small state machine lets the link be
// spliced in (ACTIVE) or out (OFF) at run time, draining in-flight work
// (DRAIN) before it terminates.
module fthread_pipe_link #(
   parameter int DATA_WIDTH = 512,
   parameter int TAG_WIDTH  = 8,
   parameter int DEPTH      = 8,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  link_en,
   input  logic                  cons_tx_rd_valid,
   input  logic [TAG_WIDTH-1:0]  cons_tx_rd_tag,
   output logic                  cons_tx_rd_ready,
   output logic                  prod_tx_rd_valid,
   output logic [TAG_WIDTH-1:0]  prod_tx_rd_tag,
   input  logic                  prod_tx_rd_ready,
   input  logic                  prod_rx_rd_valid,
   input  logic [TAG_WIDTH-1:0]  prod_rx_rd_tag,
   input  logic [DATA_WIDTH-1:0] prod_rx_data,
   output logic                  prod_rx_rd_ready,
   output logic                  cons_rx_rd_valid,
   output logic [TAG_WIDTH-1:0]  cons_rx_rd_tag,
   output logic [DATA_WIDTH-1:0] cons_rx_data,
   input  logic                  cons_rx_rd_ready,
   output logic [CNT_W-1:0]      outstanding,
   output logic [1:0]            link_state,
   output logic                  err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = TAG_WIDTH + DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t state;

   // skid buffer: the output stage is prod_tx_rd_valid/tag, plus one spare entry
   logic                 spare_v;
   logic [TAG_WIDTH-1:0] spare_tag;

   // response storage behind the registered FIFO head
   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] mem_cnt;
   logic [CNT_W-1:0] fifo_cnt;

   logic skid_full;
   logic fifo_full;
   logic at_limit;
   logic drain_done;
   logic req_push;
   logic req_pop;
   logic rsp_acc;
   logic rsp_orphan;
   logic rsp_wr;
   logic rsp_rd;
   logic head_load;
   logic mem_pop;
   logic rsp_bypass;
   logic mem_push;

   assign link_state = state;

   assign skid_full  = prod_tx_rd_valid & spare_v;
   assign fifo_cnt   = mem_cnt + CNT_W'(cons_rx_rd_valid);
   assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
   assign at_limit   = (outstanding == CNT_W'(DEPTH));
   // head empty implies storage empty, so the head valid alone marks FIFO empty
   assign drain_done = (outstanding == '0) & ~prod_tx_rd_valid & ~cons_rx_rd_valid;

   assign req_push   = cons_tx_rd_valid & cons_tx_rd_ready & (state == ST_ACTIVE);
   assign req_pop    = prod_tx_rd_valid & prod_tx_rd_ready;
   assign rsp_acc    = prod_rx_rd_valid & prod_rx_rd_ready;
   assign rsp_orphan = rsp_acc & (outstanding == '0);
   assign rsp_wr     = rsp_acc & ~rsp_orphan & (state != ST_OFF);
   assign rsp_rd     = cons_rx_rd_valid & cons_rx_rd_ready;
   assign head_load  = ~cons_rx_rd_valid | rsp_rd;
   assign mem_pop    = head_load & (mem_cnt != '0);
   // an arriving response goes straight into an empty/vacating head register
   assign rsp_bypass = rsp_wr & head_load & (mem_cnt == '0);
   assign mem_push   = rsp_wr & ~rsp_bypass;

   // readies depend only on state, occupancy and credit count
   always_comb begin
      cons_tx_rd_ready = 1'b1;
      prod_rx_rd_ready = 1'b1;
      case (state)
         ST_ACTIVE: begin
            cons_tx_rd_ready = ~skid_full & ~at_limit;
            prod_rx_rd_ready = ~fifo_full;
         end
         ST_DRAIN: begin
            cons_tx_rd_ready = 1'b0;
            prod_rx_rd_ready = ~fifo_full;
         end
         default: ;
      endcase
   end

   // link state machine, credit counter and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_OFF;
         outstanding <= '0;
         err         <= 1'b0;
      end else if (flush) begin
         state       <= link_en ? ST_ACTIVE : ST_OFF;
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         if (rsp_orphan)
            err <= 1'b1;
         if (req_push && !rsp_rd)
            outstanding <= outstanding + CNT_W'(1);
         else if (rsp_rd && !req_push && outstanding != '0)
            outstanding <= outstanding - CNT_W'(1);
         case (state)
            ST_OFF:    if (link_en) state <= ST_ACTIVE;
            ST_ACTIVE: if (!link_en) state <= ST_DRAIN;
            ST_DRAIN: begin
               if (link_en)
                  state <= ST_ACTIVE;
               else if (drain_done)
                  state <= ST_OFF;
            end
            default:   state <= ST_OFF;
         endcase
      end
   end

   // request skid buffer: refill the output stage from the spare entry first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_tx_rd_valid <= 1'b0;
         prod_tx_rd_tag   <= '0;
         spare_v          <= 1'b0;
         spare_tag        <= '0;
      end else if (flush) begin
         prod_tx_rd_valid <= 1'b0;
         spare_v          <= 1'b0;
      end else if (!prod_tx_rd_valid || req_pop) begin
         if (spare_v) begin
            prod_tx_rd_tag <= spare_tag;
            spare_v        <= req_push;
            if (req_push)
               spare_tag <= cons_tx_rd_tag;
         end else begin
            prod_tx_rd_valid <= req_push;
            if (req_push)
               prod_tx_rd_tag <= cons_tx_rd_tag;
         end
      end else if (req_push) begin
         spare_v   <= 1'b1;
         spare_tag <= cons_tx_rd_tag;
      end
   end

   // response FIFO head register and storage pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cons_rx_rd_valid <= 1'b0;
         cons_rx_rd_tag   <= '0;
         cons_rx_data     <= '0;
         wptr             <= '0;
         rptr             <= '0;
         mem_cnt          <= '0;
      end else if (flush) begin
         cons_rx_rd_valid <= 1'b0;
         wptr             <= '0;
         rptr             <= '0;
         mem_cnt          <= '0;
      end else begin
         if (head_load) begin
            if (mem_cnt != '0) begin
               cons_rx_rd_valid               <= 1'b1;
               {cons_rx_rd_tag, cons_rx_data} <= mem[rptr];
            end else if (rsp_wr) begin
               cons_rx_rd_valid <= 1'b1;
               cons_rx_rd_tag   <= prod_rx_rd_tag;
               cons_rx_data     <= prod_rx_data;
            end else begin
               cons_rx_rd_valid <= 1'b0;
            end
         end
         if (mem_pop)
            rptr <= rptr + PTR_W'(1);
         if (mem_push)
            wptr <= wptr + PTR_W'(1);
         if (mem_push && !mem_pop)
            mem_cnt <= mem_cnt + CNT_W'(1);
         else if (mem_pop && !mem_push)
            mem_cnt <= mem_cnt - CNT_W'(1);
      end
   end

   // response storage array (not reset; only read behind a valid count)
   always_ff @(posedge clk) begin
      if (!flush && mem_push)
         mem[wptr] <= {prod_rx_rd_tag, prod_rx_data};
   end

endmodule

// File: tb/tb_fthread_pipe_link.sv
// Self-checking bench for fthread_pipe_link: queue-based reference model,
// per-cycle compare of all outputs, directed scenarios and random traffic.
module tb_fthread_pipe_link;

   localparam int DW    = 512;
   localparam int TW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          link_en = 1'b0;
   logic          cons_tx_rd_valid = 1'b0;
   logic [TW-1:0] cons_tx_rd_tag = '0;
   logic          cons_tx_rd_ready;
   logic          prod_tx_rd_valid;
   logic [TW-1:0] prod_tx_rd_tag;
   logic          prod_tx_rd_ready = 1'b0;
   logic          prod_rx_rd_valid = 1'b0;
   logic [TW-1:0] prod_rx_rd_tag = '0;
   logic [DW-1:0] prod_rx_data = '0;
   logic          prod_rx_rd_ready;
   logic          cons_rx_rd_valid;
   logic [TW-1:0] cons_rx_rd_tag;
   logic [DW-1:0] cons_rx_data;
   logic          cons_rx_rd_ready = 1'b0;
   logic [CW-1:0] outstanding;
   logic [1:0]    link_state;
   logic          err;

   fthread_pipe_link #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .link_en(link_en),
      .cons_tx_rd_valid(cons_tx_rd_valid), .cons_tx_rd_tag(cons_tx_rd_tag),
      .cons_tx_rd_ready(cons_tx_rd_ready),
      .prod_tx_rd_valid(prod_tx_rd_valid), .prod_tx_rd_tag(prod_tx_rd_tag),
      .prod_tx_rd_ready(prod_tx_rd_ready),
      .prod_rx_rd_valid(prod_rx_rd_valid), .prod_rx_rd_tag(prod_rx_rd_tag),
      .prod_rx_data(prod_rx_data), .prod_rx_rd_ready(prod_rx_rd_ready),
      .cons_rx_rd_valid(cons_rx_rd_valid), .cons_rx_rd_tag(cons_rx_rd_tag),
      .cons_rx_data(cons_rx_data), .cons_rx_rd_ready(cons_rx_rd_ready),
      .outstanding(outstanding), .link_state(link_state), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model: 0 OFF, 1 ACTIVE, 2 DRAIN
   int               m_state = 0;
   int               m_out = 0;
   bit               m_err = 0;
   logic [TW-1:0]    req_q[$];
   logic [TW+DW-1:0] rsp_q[$];

   // bench-side producer and stimulus knobs
   logic [TW-1:0]    pend[$];
   logic [TW+DW-1:0] got_q[$];
   logic [TW-1:0]    ptx_q[$];
   int               ptx_cyc[$];
   bit               req_taken = 0;
   bit               rsp_taken = 0;
   int               req_left = 0;
   logic [TW-1:0]    next_tag = '0;
   bit               rsp_en = 0;
   bit               rsp_rand_data = 0;
   bit               rand_mode = 0;
   int               p_req = 0;
   int               p_ptx = 100;
   int               p_crx = 100;
   int               p_rsp = 100;

   function automatic bit e_ctx_rdy();
      if (m_state == 0) return 1'b1;
      if (m_state == 1) return (req_q.size() < 2) && (m_out < DEPTH);
      return 1'b0;
   endfunction

   function automatic bit e_prx_rdy();
      if (m_state == 0) return 1'b1;
      return rsp_q.size() < DEPTH;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // advance the model by one clock edge using the inputs seen at that edge
   task automatic model_step();
      bit ra, rp, ri, ro;
      int old_state, old_out, old_req, old_rsp;
      req_taken = 0;
      rsp_taken = 0;
      if (!rst_n) begin
         m_state = 0; m_out = 0; m_err = 0;
         req_q.delete(); rsp_q.delete(); pend.delete();
         return;
      end
      ra = cons_tx_rd_valid && e_ctx_rdy();
      rp = (req_q.size() > 0) && prod_tx_rd_ready;
      ri = prod_rx_rd_valid && e_prx_rdy();
      ro = (rsp_q.size() > 0) && cons_rx_rd_ready;
      if (flush) begin
         m_state = link_en ? 1 : 0;
         m_out = 0; m_err = 0;
         req_q.delete(); rsp_q.delete(); pend.delete();
         rsp_taken = prod_rx_rd_valid;
         return;
      end
      old_state = m_state; old_out = m_out;
      old_req = req_q.size(); old_rsp = rsp_q.size();
      if (rp) pend.push_back(req_q.pop_front());
      if (ra) begin
         req_taken = 1;
         if (old_state == 1) begin
            req_q.push_back(cons_tx_rd_tag);
            m_out++;
         end
      end
      if (ro) begin
         void'(rsp_q.pop_front());
         if (m_out > 0) m_out--;
      end
      if (ri) begin
         rsp_taken = 1;
         if (pend.size() > 0) void'(pend.pop_front());
         if (old_out == 0) m_err = 1;
         else if (old_state != 0) rsp_q.push_back({prod_rx_rd_tag, prod_rx_data});
      end
      case (old_state)
         0: if (link_en) m_state = 1;
         1: if (!link_en) m_state = 2;
         default: begin
            if (link_en) m_state = 1;
            else if (old_out == 0 && old_req == 0 && old_rsp == 0) m_state = 0;
         end
      endcase
   endtask

   task automatic check_all();
      logic [TW+DW-1:0] h;
      logic [TW-1:0]    qt;
      chk("link_state", DW'(link_state), DW'(m_state));
      chk("outstanding", DW'(outstanding), DW'(m_out));
      chk("err", DW'(err), DW'(m_err));
      chk("cons_tx_rd_ready", DW'(cons_tx_rd_ready), DW'(e_ctx_rdy()));
      chk("prod_rx_rd_ready", DW'(prod_rx_rd_ready), DW'(e_prx_rdy()));
      chk("prod_tx_rd_valid", DW'(prod_tx_rd_valid), DW'(req_q.size() > 0));
      chk("cons_rx_rd_valid", DW'(cons_rx_rd_valid), DW'(rsp_q.size() > 0));
      if (req_q.size() > 0) begin
         qt = req_q[0];
         chk("prod_tx_rd_tag", DW'(prod_tx_rd_tag), DW'(qt));
      end
      if (rsp_q.size() > 0) begin
         h = rsp_q[0];
         chk("cons_rx_rd_tag", DW'(cons_rx_rd_tag), DW'(h[TW+DW-1:DW]));
         chk("cons_rx_data", cons_rx_data, h[DW-1:0]);
      end
   endtask

   // choose the next cycle's inputs from the current knobs
   task automatic drive();
      logic [DW-1:0] d;
      if (req_taken && req_left > 0) begin
         req_left--;
         next_tag = next_tag + 8'd1;
      end
      if (rsp_taken) prod_rx_rd_valid = 1'b0;
      flush = 1'b0;
      if (rand_mode) begin
         if ($urandom_range(49) == 0) link_en = ~link_en;
         flush = ($urandom_range(199) == 0);
      end
      if (req_left > 0) begin
         cons_tx_rd_valid = 1'b1;
         cons_tx_rd_tag   = next_tag;
      end else if (rand_mode) begin
         cons_tx_rd_valid = ($urandom_range(99) < p_req);
         cons_tx_rd_tag   = TW'($urandom);
      end else begin
         cons_tx_rd_valid = 1'b0;
      end
      prod_tx_rd_ready = ($urandom_range(99) < p_ptx);
      cons_rx_rd_ready = ($urandom_range(99) < p_crx);
      if (!prod_rx_rd_valid && rsp_en && pend.size() > 0 && $urandom_range(99) < p_rsp) begin
         prod_rx_rd_valid = 1'b1;
         prod_rx_rd_tag   = pend[0];
         if (rsp_rand_data) begin
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
         end else begin
            d = DW'(pend[0]) * DW'(17);
         end
         prod_rx_data = d;
      end
   endtask

   task automatic tick();
      if (cons_rx_rd_valid && cons_rx_rd_ready) got_q.push_back({cons_rx_rd_tag, cons_rx_data});
      if (prod_tx_rd_valid && prod_tx_rd_ready) begin
         ptx_q.push_back(prod_tx_rd_tag);
         ptx_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      if (rst_n) check_all();
      drive();
   endtask

   initial begin
      logic [TW+DW-1:0] g;
      int bound;

      // reset values, including combinational readies during reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_state", DW'(link_state), DW'(0));
      chk("rst_outstanding", DW'(outstanding), DW'(0));
      chk("rst_err", DW'(err), DW'(0));
      chk("rst_cons_tx_ready", DW'(cons_tx_rd_ready), DW'(1));
      chk("rst_prod_rx_ready", DW'(prod_rx_rd_ready), DW'(1));
      chk("rst_prod_tx_valid", DW'(prod_tx_rd_valid), DW'(0));
      chk("rst_cons_rx_valid", DW'(cons_rx_rd_valid), DW'(0));
      chk("rst_cons_rx_data", cons_rx_data, '0);
      rst_n = 1'b1;

      // A: 8 back-to-back requests, in-order responses with data = tag*0x11
      link_en = 1'b1;
      tick();
      chk("A_active", DW'(link_state), DW'(1));
      rsp_en = 1; p_ptx = 100; p_crx = 100; p_rsp = 100;
      next_tag = 8'h00; req_left = 8;
      got_q.delete(); ptx_q.delete(); ptx_cyc.delete();
      bound = 0;
      while (got_q.size() < 8 && bound < 40) begin tick(); bound++; end
      chk("A_delivered", DW'(got_q.size()), DW'(8));
      chk("A_issued", DW'(ptx_q.size()), DW'(8));
      if (ptx_cyc.size() == 8) chk("A_issue_span", DW'(ptx_cyc[7] - ptx_cyc[0]), DW'(7));
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         g = got_q[i];
         chk("A_rsp_tag", DW'(g[TW+DW-1:DW]), DW'(i));
         chk("A_rsp_data", g[DW-1:0], DW'(i * 17));
         chk("A_req_tag", DW'(ptx_q[i]), DW'(i));
      end
      tick();
      chk("A_end_outstanding", DW'(outstanding), DW'(0));

      // B: producer withholds responses, consumer offers 12 requests
      rsp_en = 0; next_tag = 8'h20; req_left = 12;
      repeat (14) tick();
      chk("B_outstanding_full", DW'(outstanding), DW'(8));
      chk("B_ready_closed", DW'(cons_tx_rd_ready), DW'(0));
      chk("B_accepted", DW'(12 - req_left), DW'(8));
      rsp_en = 1;
      bound = 0;
      while ((req_left > 0 || outstanding != 0) && bound < 60) begin tick(); bound++; end
      chk("B_all_accepted", DW'(req_left), DW'(0));
      chk("B_end_outstanding", DW'(outstanding), DW'(0));

      // C: 4 outstanding, then link disabled -> drain -> off
      rsp_en = 0; next_tag = 8'h30; req_left = 4;
      repeat (6) tick();
      chk("C_outstanding", DW'(outstanding), DW'(4));
      link_en = 1'b0; rsp_en = 1;
      tick();
      chk("C_drain", DW'(link_state), DW'(2));
      chk("C_drain_ready", DW'(cons_tx_rd_ready), DW'(0));
      bound = 0;
      while (link_state != 2'd0 && bound < 40) begin tick(); bound++; end
      chk("C_off", DW'(link_state), DW'(0));
      chk("C_off_outstanding", DW'(outstanding), DW'(0));
      next_tag = 8'h38; req_left = 3;
      repeat (5) tick();
      chk("C_dropped_all", DW'(req_left), DW'(0));
      chk("C_dropped_outstanding", DW'(outstanding), DW'(0));
      chk("C_dropped_no_issue", DW'(prod_tx_rd_valid), DW'(0));

      // D: stray response while OFF sets sticky err
      prod_rx_rd_valid = 1'b1; prod_rx_rd_tag = 8'h03; prod_rx_data = DW'(3);
      chk("D_prod_rx_ready", DW'(prod_rx_rd_ready), DW'(1));
      tick();
      chk("D_err_set", DW'(err), DW'(1));
      chk("D_no_delivery", DW'(cons_rx_rd_valid), DW'(0));
      repeat (3) tick();
      chk("D_err_sticky", DW'(err), DW'(1));
      flush = 1'b1;
      tick();
      chk("D_err_cleared", DW'(err), DW'(0));
      chk("D_flush_off", DW'(link_state), DW'(0));

      // E: consumer back-pressure fills the FIFO, then releases in order
      link_en = 1'b1;
      tick();
      p_crx = 0; rsp_en = 1; next_tag = 8'h40; req_left = 8;
      repeat (20) tick();
      chk("E_fifo_full", DW'(prod_rx_rd_ready), DW'(0));
      chk("E_outstanding", DW'(outstanding), DW'(8));
      chk("E_head_tag", DW'(cons_rx_rd_tag), DW'(8'h40));
      got_q.delete(); p_crx = 100;
      bound = 0;
      while (got_q.size() < 8 && bound < 30) begin tick(); bound++; end
      chk("E_delivered", DW'(got_q.size()), DW'(8));
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         g = got_q[i];
         chk("E_rsp_tag", DW'(g[TW+DW-1:DW]), DW'(8'h40 + i));
         chk("E_rsp_data", g[DW-1:0], DW'((8'h40 + i) * 17));
      end

      // F: flush with 5 outstanding and a simultaneous request accept
      rsp_en = 0; next_tag = 8'h60; req_left = 5;
      repeat (8) tick();
      chk("F_outstanding", DW'(outstanding), DW'(5));
      cons_tx_rd_valid = 1'b1; cons_tx_rd_tag = 8'h66; flush = 1'b1;
      chk("F_accept_open", DW'(cons_tx_rd_ready), DW'(1));
      tick();
      chk("F_outstanding_zero", DW'(outstanding), DW'(0));
      chk("F_fifo_empty", DW'(cons_rx_rd_valid), DW'(0));
      chk("F_skid_empty", DW'(prod_tx_rd_valid), DW'(0));
      chk("F_err", DW'(err), DW'(0));
      chk("F_active", DW'(link_state), DW'(1));

      // G: random traffic with link toggling and occasional flush
      rand_mode = 1; rsp_en = 1; rsp_rand_data = 1;
      for (int blk = 0; blk < 15; blk++) begin
         p_req = $urandom_range(100);
         p_ptx = $urandom_range(20, 100);
         p_crx = $urandom_range(100);
         p_rsp = $urandom_range(20, 100);
         repeat (200) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
